// File: rtl/lc3_decode.sv
// -----------------------------------------------------------------------------
// lc3_decode
// Decode stage of the LC3 pipeline. Registers the fetched instruction and its
// next-PC, builds the execute/memory/writeback control words, and compares the
// incoming source registers against the previous enabled instruction's
// destination register to drive the ALU/memory bypass selects.
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   enable_decode       : stage advance; low holds every output and the history
//   dout[15:0]          : instruction word from instruction memory
//   npc_in[15:0]        : PC+1 from fetch
//   IR[15:0]            : registered instruction
//   npc_out[15:0]       : registered npc_in
//   E_control[5:0]      : {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   W_control[1:0]      : writeback select (0 ALU, 1 memory, 2 LEA)
//   Mem_control         : 1 = indirect access (LDI/STI)
//   bypass_alu_1/2      : SR1/SR2 forwarded from previous ALU/LEA result
//   bypass_mem_1/2      : SR1/SR2 forwarded from previous load data
//   illegal_op          : registered instruction's opcode is not decoded
// -----------------------------------------------------------------------------
module lc3_decode (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_control,
    output logic [1:0]  W_control,
    output logic        Mem_control,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2,
    output logic        illegal_op
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    logic [15:0] ir_q,  ir_d;
    logic [15:0] npc_q, npc_d;
    logic [5:0]  e_ctrl_q, e_ctrl_d;
    logic [1:0]  w_ctrl_q, w_ctrl_d;
    logic        mem_ctrl_q, mem_ctrl_d;
    logic [3:0]  bypass_q, bypass_d;      // {alu_1, alu_2, mem_1, mem_2}
    logic        illegal_q, illegal_d;
    logic        hist_valid_q, hist_valid_d;
    logic [2:0]  hist_dr_q, hist_dr_d;
    logic        hist_is_load_q, hist_is_load_d;

    // Combinational decode of the incoming word
    logic [3:0]  opcode_s;
    logic [5:0]  e_ctrl_s;
    logic [1:0]  w_ctrl_s;
    logic        mem_ctrl_s;
    logic        illegal_s;
    logic        writer_s;
    logic        is_load_s;
    logic        sr1_used_s;
    logic        sr2_used_s;
    logic [2:0]  sr1_s;
    logic [2:0]  sr2_s;
    logic        match1_s;
    logic        match2_s;

    assign opcode_s = dout[15:12];
    assign sr1_s    = dout[8:6];

    // Opcode decode: control words, register usage and writer/load flags
    always_comb begin
        e_ctrl_s   = 6'b000000;
        w_ctrl_s   = 2'b00;
        mem_ctrl_s = 1'b0;
        illegal_s  = 1'b0;
        writer_s   = 1'b0;
        is_load_s  = 1'b0;
        sr1_used_s = 1'b0;
        sr2_used_s = 1'b0;
        sr2_s      = dout[2:0];
        case (opcode_s)
            OP_ADD: begin
                e_ctrl_s   = {2'b00, 2'b00, 1'b0, ~dout[5]};
                writer_s   = 1'b1;
                sr1_used_s = 1'b1;
                sr2_used_s = ~dout[5];
            end
            OP_AND: begin
                e_ctrl_s   = {2'b01, 2'b00, 1'b0, ~dout[5]};
                writer_s   = 1'b1;
                sr1_used_s = 1'b1;
                sr2_used_s = ~dout[5];
            end
            OP_NOT: begin
                e_ctrl_s   = {2'b10, 2'b00, 1'b0, 1'b0};
                writer_s   = 1'b1;
                sr1_used_s = 1'b1;
            end
            OP_BR: begin
                e_ctrl_s   = {2'b00, 2'b01, 1'b1, 1'b0};
            end
            OP_JMP: begin
                e_ctrl_s   = {2'b00, 2'b11, 1'b0, 1'b0};
                sr1_used_s = 1'b1;
            end
            OP_LD: begin
                e_ctrl_s   = {2'b00, 2'b01, 1'b1, 1'b0};
                w_ctrl_s   = 2'd1;
                writer_s   = 1'b1;
                is_load_s  = 1'b1;
            end
            OP_LDR: begin
                e_ctrl_s   = {2'b00, 2'b10, 1'b0, 1'b0};
                w_ctrl_s   = 2'd1;
                writer_s   = 1'b1;
                is_load_s  = 1'b1;
                sr1_used_s = 1'b1;
            end
            OP_LDI: begin
                e_ctrl_s   = {2'b00, 2'b01, 1'b1, 1'b0};
                w_ctrl_s   = 2'd1;
                mem_ctrl_s = 1'b1;
                writer_s   = 1'b1;
                is_load_s  = 1'b1;
            end
            OP_LEA: begin
                e_ctrl_s   = {2'b00, 2'b01, 1'b1, 1'b0};
                w_ctrl_s   = 2'd2;
                writer_s   = 1'b1;
            end
            OP_ST: begin
                e_ctrl_s   = {2'b00, 2'b01, 1'b1, 1'b0};
                sr2_s      = dout[11:9];
                sr2_used_s = 1'b1;
            end
            OP_STR: begin
                e_ctrl_s   = {2'b00, 2'b10, 1'b0, 1'b0};
                sr2_s      = dout[11:9];
                sr1_used_s = 1'b1;
                sr2_used_s = 1'b1;
            end
            OP_STI: begin
                e_ctrl_s   = {2'b00, 2'b01, 1'b1, 1'b0};
                mem_ctrl_s = 1'b1;
                sr2_s      = dout[11:9];
                sr2_used_s = 1'b1;
            end
            default: begin
                illegal_s  = 1'b1;
            end
        endcase
    end

    // Source match against the history as it stands before this edge updates it
    assign match1_s = sr1_used_s & hist_valid_q & (sr1_s == hist_dr_q);
    assign match2_s = sr2_used_s & hist_valid_q & (sr2_s == hist_dr_q);

    // Next-state selection: advance on enable, otherwise hold everything
    always_comb begin
        ir_d           = ir_q;
        npc_d          = npc_q;
        e_ctrl_d       = e_ctrl_q;
        w_ctrl_d       = w_ctrl_q;
        mem_ctrl_d     = mem_ctrl_q;
        bypass_d       = bypass_q;
        illegal_d      = illegal_q;
        hist_valid_d   = hist_valid_q;
        hist_dr_d      = hist_dr_q;
        hist_is_load_d = hist_is_load_q;
        if (enable_decode) begin
            ir_d           = dout;
            npc_d          = npc_in;
            e_ctrl_d       = e_ctrl_s;
            w_ctrl_d       = w_ctrl_s;
            mem_ctrl_d     = mem_ctrl_s;
            illegal_d      = illegal_s;
            bypass_d       = {match1_s & ~hist_is_load_q, match2_s & ~hist_is_load_q,
                              match1_s &  hist_is_load_q, match2_s &  hist_is_load_q};
            hist_valid_d   = writer_s;
            hist_dr_d      = dout[11:9];
            hist_is_load_d = is_load_s;
        end else begin
            ir_d           = ir_q;
        end
    end

    // Pipeline register and history with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_q           <= 16'h0000;
            npc_q          <= 16'h0000;
            e_ctrl_q       <= 6'b000000;
            w_ctrl_q       <= 2'b00;
            mem_ctrl_q     <= 1'b0;
            bypass_q       <= 4'b0000;
            illegal_q      <= 1'b0;
            hist_valid_q   <= 1'b0;
            hist_dr_q      <= 3'b000;
            hist_is_load_q <= 1'b0;
        end else begin
            ir_q           <= ir_d;
            npc_q          <= npc_d;
            e_ctrl_q       <= e_ctrl_d;
            w_ctrl_q       <= w_ctrl_d;
            mem_ctrl_q     <= mem_ctrl_d;
            bypass_q       <= bypass_d;
            illegal_q      <= illegal_d;
            hist_valid_q   <= hist_valid_d;
            hist_dr_q      <= hist_dr_d;
            hist_is_load_q <= hist_is_load_d;
        end
    end

    assign IR           = ir_q;
    assign npc_out      = npc_q;
    assign E_control    = e_ctrl_q;
    assign W_control    = w_ctrl_q;
    assign Mem_control  = mem_ctrl_q;
    assign bypass_alu_1 = bypass_q[3];
    assign bypass_alu_2 = bypass_q[2];
    assign bypass_mem_1 = bypass_q[1];
    assign bypass_mem_2 = bypass_q[0];
    assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_lc3_decode.sv
// -----------------------------------------------------------------------------
// tb_lc3_decode
// Directed bench for lc3_decode: each step drives one instruction, waits one
// enabled edge and compares every output against hand-derived values.
// -----------------------------------------------------------------------------
module tb_lc3_decode;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_decode = 1'b0;
    logic [15:0] dout = 16'h0000;
    logic [15:0] npc_in = 16'h0000;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_control;
    logic [1:0]  W_control;
    logic        Mem_control;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic        illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    lc3_decode dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .dout          (dout),
        .npc_in        (npc_in),
        .IR            (IR),
        .npc_out       (npc_out),
        .E_control     (E_control),
        .W_control     (W_control),
        .Mem_control   (Mem_control),
        .bypass_alu_1  (bypass_alu_1),
        .bypass_alu_2  (bypass_alu_2),
        .bypass_mem_1  (bypass_mem_1),
        .bypass_mem_2  (bypass_mem_2),
        .illegal_op    (illegal_op)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // byp = {alu_1, alu_2, mem_1, mem_2}
    task automatic expect_out(input string tag, input logic [15:0] ir, input logic [15:0] npc,
                              input logic [5:0] e, input logic [1:0] w, input logic m,
                              input logic [3:0] byp, input logic ill);
        chk({tag, ".IR"},   IR, ir);
        chk({tag, ".npc"},  npc_out, npc);
        chk({tag, ".E"},    {10'd0, E_control}, {10'd0, e});
        chk({tag, ".W"},    {14'd0, W_control}, {14'd0, w});
        chk({tag, ".Mem"},  {15'd0, Mem_control}, {15'd0, m});
        chk({tag, ".byp"},  {12'd0, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2},
                            {12'd0, byp});
        chk({tag, ".ill"},  {15'd0, illegal_op}, {15'd0, ill});
    endtask

    task automatic step(input logic [15:0] instr, input logic [15:0] npc);
        dout          = instr;
        npc_in        = npc;
        enable_decode = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        expect_out("reset", 16'h0000, 16'h0000, 6'b000000, 2'd0, 1'b0, 4'b0000, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Immediate ADD then register ADD
        step(16'h12A3, 16'h3001);
        expect_out("add_imm", 16'h12A3, 16'h3001, 6'b000000, 2'd0, 1'b0, 4'b0000, 1'b0);
        step(16'h1642, 16'h3002);
        expect_out("add_reg", 16'h1642, 16'h3002, 6'b000001, 2'd0, 1'b0, 4'b1000, 1'b0);

        // Load-use chain
        step(16'h68C5, 16'h3003);
        expect_out("ldr", 16'h68C5, 16'h3003, 6'b001000, 2'd1, 1'b0, 4'b1000, 1'b0);
        step(16'h1B04, 16'h3004);
        expect_out("load_use", 16'h1B04, 16'h3004, 6'b000001, 2'd0, 1'b0, 4'b0011, 1'b0);

        // Control words
        step(16'hE1FF, 16'h3005);
        expect_out("lea", 16'hE1FF, 16'h3005, 6'b000110, 2'd2, 1'b0, 4'b0000, 1'b0);
        step(16'hB404, 16'h3006);
        expect_out("sti", 16'hB404, 16'h3006, 6'b000110, 2'd0, 1'b1, 4'b0000, 1'b0);
        step(16'hC1C0, 16'h3007);
        expect_out("jmp", 16'hC1C0, 16'h3007, 6'b001100, 2'd0, 1'b0, 4'b0000, 1'b0);
        step(16'h5E3F, 16'h3008);
        expect_out("and_imm", 16'h5E3F, 16'h3008, 6'b010000, 2'd0, 1'b0, 4'b0000, 1'b0);
        step(16'h9FFF, 16'h3009);
        expect_out("not", 16'h9FFF, 16'h3009, 6'b100000, 2'd0, 1'b0, 4'b1000, 1'b0);
        step(16'h2E01, 16'h300A);
        expect_out("ld", 16'h2E01, 16'h300A, 6'b000110, 2'd1, 1'b0, 4'b0000, 1'b0);
        step(16'h7FC0, 16'h300B);
        expect_out("str", 16'h7FC0, 16'h300B, 6'b001000, 2'd0, 1'b0, 4'b0011, 1'b0);
        step(16'hA000, 16'h300C);
        expect_out("ldi", 16'hA000, 16'h300C, 6'b000110, 2'd1, 1'b1, 4'b0000, 1'b0);
        step(16'h3000, 16'h300D);
        expect_out("st", 16'h3000, 16'h300D, 6'b000110, 2'd0, 1'b0, 4'b0001, 1'b0);
        step(16'h0E05, 16'h300E);
        expect_out("br", 16'h0E05, 16'h300E, 6'b000110, 2'd0, 1'b0, 4'b0000, 1'b0);

        // Illegal opcode invalidates the history
        step(16'h12A3, 16'h300F);
        expect_out("pre_ill", 16'h12A3, 16'h300F, 6'b000000, 2'd0, 1'b0, 4'b0000, 1'b0);
        step(16'hD000, 16'h3010);
        expect_out("illegal", 16'hD000, 16'h3010, 6'b000000, 2'd0, 1'b0, 4'b0000, 1'b1);
        step(16'h1242, 16'h3011);
        expect_out("post_ill", 16'h1242, 16'h3011, 6'b000001, 2'd0, 1'b0, 4'b0000, 1'b0);
        step(16'hF025, 16'h3012);
        expect_out("trap_ill", 16'hF025, 16'h3012, 6'b000000, 2'd0, 1'b0, 4'b0000, 1'b1);

        // Stall: outputs and history frozen while dout toggles
        step(16'h1642, 16'h3013);
        expect_out("pre_stall", 16'h1642, 16'h3013, 6'b000001, 2'd0, 1'b0, 4'b0000, 1'b0);
        enable_decode = 1'b0;
        npc_in        = 16'h3001;
        for (int i = 0; i < 5; i++) begin
            dout = (i % 2 == 0) ? 16'h6000 : 16'hDEAD;
            @(posedge clock);
            #1;
            expect_out("stall", 16'h1642, 16'h3013, 6'b000001, 2'd0, 1'b0, 4'b0000, 1'b0);
        end
        step(16'h16C3, 16'h3001);
        expect_out("reenable", 16'h16C3, 16'h3001, 6'b000001, 2'd0, 1'b0, 4'b1100, 1'b0);

        // Asynchronous reset mid-cycle
        step(16'h12A3, 16'h3020);
        expect_out("pre_rst", 16'h12A3, 16'h3020, 6'b000000, 2'd0, 1'b0, 4'b0000, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        expect_out("async_rst", 16'h0000, 16'h0000, 6'b000000, 2'd0, 1'b0, 4'b0000, 1'b0);
        #1;
        reset = 1'b0;
        step(16'h1642, 16'h3021);
        expect_out("post_rst", 16'h1642, 16'h3021, 6'b000001, 2'd0, 1'b0, 4'b0000, 1'b0);

        // Reset wins over a simultaneous enabled edge
        reset = 1'b1;
        step(16'h1642, 16'h3022);
        expect_out("rst_wins", 16'h0000, 16'h0000, 6'b000000, 2'd0, 1'b0, 4'b0000, 1'b0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_decode.md
# lc3_decode

Decode stage of the LC3 pipeline. Sits between fetch/instruction memory and the execute stage. It registers the fetched instruction and its next-PC, and generates the execute, memory and writeback control words. It also tracks the previous instruction's destination register so that it can drive the ALU/memory bypass selects into execute. All outputs are registered and advance only when `enable_decode` is high.

## Interface
- No parameters; all widths fixed by the LC3 ISA.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enable_decode`  in  1  stage advance; when low, all outputs and internal history hold.
- `dout`  in  16  instruction word from instruction memory.
- `npc_in`  in  16  PC+1 from fetch.
- `IR`  out  16  registered instruction.
- `npc_out`  out  16  registered `npc_in`.
- `E_control`  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- `W_control`  out  2  writeback select: 0 ALU, 1 memory, 2 PC-relative (LEA).
- `Mem_control`  out  1  1 = indirect access (LDI/STI).
- `bypass_alu_1`, `bypass_alu_2`  out  1 each  SR1/SR2 forwarded from the previous instruction's ALU/LEA result.
- `bypass_mem_1`, `bypass_mem_2`  out  1 each  SR1/SR2 forwarded from the previous instruction's load data.
- `illegal_op`  out  1  registered instruction's opcode is not decoded.

## Operation
- **Decode table** (opcode `dout[15:12]`). The E_control fields are alu, pcsel1, pcsel2, op2sel. Any field not listed is 0.
  - ADD 0001: alu 00, op2sel = ~dout[5]; W 0.
  - AND 0101: alu 01, op2sel = ~dout[5]; W 0.
  - NOT 1001: alu 10; W 0.
  - BR 0000: pcsel1 01, pcsel2 1.
  - JMP 1100: pcsel1 11, pcsel2 0.
  - LD 0010: pcsel1 01, pcsel2 1; W 1; Mem 0.
  - LDR 0110: pcsel1 10, pcsel2 0; W 1.
  - LDI 1010: pcsel1 01, pcsel2 1; W 1; Mem 1.
  - LEA 1110: pcsel1 01, pcsel2 1; W 2.
  - ST 0011: pcsel1 01, pcsel2 1; Mem 0.
  - STR 0111: pcsel1 10.
  - STI 1011: pcsel1 01, pcsel2 1; Mem 1.
  - All other opcodes (1000, 0100, 1101, 1111): every control output is 0 and `illegal_op` = 1.
- **Register writers:** ADD, AND, NOT, LD, LDR, LDI, LEA. For these, DR = `dout[11:9]`.
- **Source registers:**
  - SR1 = `dout[8:6]` for ADD, AND, NOT, JMP, LDR, STR.
  - SR2 = `dout[2:0]` for ADD/AND with `dout[5]`=0.
  - SR2 = `dout[11:9]` for ST, STR, STI (store data).
  - Each source has a use flag; an unused source never raises a bypass.
- **History register** `{hist_valid, hist_dr[2:0], hist_is_load}`:
  - Loaded on every enabled edge from the instruction being decoded.
  - `hist_valid` = 1 only for register writers; illegal opcodes and non-writers load `hist_valid` = 0.
  - `hist_is_load` = 1 for LD/LDR/LDI.
- **Bypass** (computed from the incoming instruction against the history before it updates):
  - `bypass_alu_n` = srn_used && hist_valid && srn == hist_dr && !hist_is_load.
  - `bypass_mem_n` = same match && hist_is_load.
  - `bypass_alu_n` and `bypass_mem_n` are mutually exclusive.
- **Reset** clears `IR`, `npc_out`, `E_control`, `W_control`, `Mem_control`, all bypass outputs, `illegal_op` and the history (including `hist_valid`) to 0.

## Timing
- Latency: 1 cycle. Outputs reflect the `dout`/`npc_in` sampled at a rising edge with `enable_decode`=1.
- `enable_decode`=0: outputs and history hold indefinitely, even if `dout` changes. Bypass relations therefore refer to the previous *enabled* instruction, not the previous clock cycle.
- `reset` asserted at any time: outputs go to 0 without waiting for an edge. The first enabled edge after deassertion decodes with an empty history, so no bypass is raised.
- Simultaneous `reset` and enabled edge: reset wins.
- The history update and the bypass computation use the same edge. An instruction never bypasses against itself.

## Test plan
- **Reset:** assert `reset` mid-cycle after loading 0x12A3 → every output reads 0 before the next edge. Then decode 0x1642 → all bypass outputs are 0.
- **Immediate ADD then register ADD:**
  - 0x12A3 (ADD R1,R2,#3) → E_control 000000, W 0, bypass all 0.
  - Next, 0x1642 (ADD R3,R1,R2) → E_control 000001, `bypass_alu_1`=1, `bypass_alu_2`=0.
- **Load-use chain:**
  - 0x68C5 (LDR R4,R3,#5) after 0x1642 → E_control 001000, W 1, `bypass_alu_1`=1.
  - Then 0x1B04 (ADD R5,R4,R4) → `bypass_mem_1`=`bypass_mem_2`=1, alu bypasses 0.
- **Control words:**
  - 0xE1FF (LEA) → E 000110, W 2, Mem 0.
  - 0xB404 (STI R2) → E 000110, Mem 1, W 0.
  - 0xC1C0 (JMP R7) → E 001100.
- **Illegal opcode:** 0xD000 after 0x12A3 → all controls 0, `illegal_op`=1. Next 0x1242 (ADD R1,R1,R2) → no bypass, because the history was invalidated.
- **Stall:** hold `enable_decode`=0 for 5 cycles while `dout` toggles; also hold `npc_in`=0x3001 across the enable → outputs stay frozen; on re-enable they reflect the sampled word and `npc_out`=0x3001.
